// File: rtl/serial_alu_pkg.sv
// Shared constants for the serial add sequencer: FSM state encoding and default width.
package serial_alu_pkg;

    // Default operand/result width.
    localparam int DEFAULT_WIDTH = 8;

    // FSM state encoding, kept as plain 2-bit constants for legacy compatibility.
    typedef logic [1:0] state_t;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

endpackage

// File: rtl/serial_add_seq_if.sv
// Bundle of the upstream handshake, the serial adder link and the downstream handshake.
interface serial_add_seq_if #(
    parameter int WIDTH = serial_alu_pkg::DEFAULT_WIDTH
);
    // Operand request side
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;

    // Link to the 1-bit registered-carry adder stage
    logic             ser_a;
    logic             ser_b;
    logic             ser_cin;
    logic             ser_s;
    logic             ser_cout;

    // Result side
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;

    // The sequencer itself
    modport slave (
        input  in_valid, in_a, in_b, in_cin,
        input  ser_s, ser_cout,
        input  out_ready,
        output in_ready,
        output ser_a, ser_b, ser_cin,
        output out_valid, out_sum, out_cout
    );

    // Whatever drives operands, hosts the adder and consumes results
    modport master (
        output in_valid, in_a, in_b, in_cin,
        output ser_s, ser_cout,
        output out_ready,
        input  in_ready,
        input  ser_a, ser_b, ser_cin,
        input  out_valid, out_sum, out_cout
    );

endinterface

// File: rtl/full_adder_reg.sv
// 1-bit full-adder stage: combinational sum, carry registered each clock.
// Carry resets to 1; the sequencer never consumes that value.
module full_adder_reg (
    input  logic clk,
    input  logic rst_n,
    input  logic add_1,
    input  logic add_2,
    input  logic c_in,
    output logic s,
    output logic c_out
);

    assign s = add_1 ^ add_2 ^ c_in;

    // Capture the carry of the current bit for use by the next bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_out <= 1'b1;
        end else begin
            c_out <= (add_1 & add_2) | (c_in & (add_1 ^ add_2));
        end
    end

endmodule

// File: rtl/shift_reg_lsb.sv
// Load / shift-right register. New bits enter at the MSB; bit 0 is the serial tap.
// Only the low OUT_W bits are exported, so a pure serial-out user takes OUT_W=1.
module shift_reg_lsb #(
    parameter int WIDTH = 8,
    parameter int OUT_W = WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             shift,
    input  logic             ser_in,
    output logic [OUT_W-1:0] q_out
);

    logic [WIDTH-1:0] q_reg;

    // Parallel load wins over shift; shifting moves everything one place toward bit 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_reg <= '0;
        end else if (load) begin
            q_reg <= load_val;
        end else if (shift) begin
            q_reg <= {ser_in, q_reg[WIDTH-1:1]};
        end
    end

    assign q_out = q_reg[OUT_W-1:0];

endmodule

// File: rtl/serial_add_seq.sv
// Sequencer around a 1-bit registered-carry adder: takes parallel operands, feeds them
// LSB-first into the adder, collects sum bits and the final carry, returns a parallel result.
module serial_add_seq
    import serial_alu_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    serial_add_seq_if.slave  bus
);

    logic [1:0]       state_reg;
    logic [1:0]       state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic             cin_reg;
    logic             cout_reg;

    logic             accept;
    logic             shifting;
    logic             last_bit;
    logic [1:0]       opd_lsb;
    logic [WIDTH-1:0] opd_load_val [2];
    logic [WIDTH-1:0] sum_q;

    assign accept   = bus.in_valid && (state_reg == IDLE);
    assign shifting = (state_reg == SHIFT);
    assign last_bit = (cnt_reg == CNT_W'(WIDTH - 1));

    assign opd_load_val[0] = bus.in_a;
    assign opd_load_val[1] = bus.in_b;

    // Operand registers: index 0 is A, index 1 is B; both present their current bit at the LSB.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_opd
            shift_reg_lsb #(
                .WIDTH (WIDTH),
                .OUT_W (1)
            ) u_opd (
                .clk      (clk),
                .rst      (rst),
                .load     (accept),
                .load_val (opd_load_val[gi]),
                .shift    (shifting),
                .ser_in   (1'b0),
                .q_out    (opd_lsb[gi:gi])
            );
        end
    endgenerate

    // Sum register: cleared on accept, sum bits enter at the MSB so bit 0 ends up at the LSB.
    shift_reg_lsb #(
        .WIDTH (WIDTH),
        .OUT_W (WIDTH)
    ) u_sum (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .load_val ({WIDTH{1'b0}}),
        .shift    (shifting),
        .ser_in   (bus.ser_s),
        .q_out    (sum_q)
    );

    // Next-state logic: IDLE -> SHIFT for WIDTH bits -> FLUSH for the last carry -> DONE until taken.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept)        state_next = SHIFT;
            SHIFT:   if (last_bit)      state_next = FLUSH;
            FLUSH:                      state_next = DONE;
            DONE:    if (bus.out_ready) state_next = IDLE;
            default:                    state_next = IDLE;
        endcase
    end

    // State, bit counter, captured carry-in and final carry-out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            cin_reg   <= 1'b0;
            cout_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                cnt_reg <= '0;
                cin_reg <= bus.in_cin;
            end else if (shifting) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
            // During FLUSH the adder's carry register holds the carry out of the MSB.
            if (state_reg == FLUSH) begin
                cout_reg <= bus.ser_cout;
            end
        end
    end

    // Bit 0 takes the captured carry-in; later bits chain the adder's registered carry.
    assign bus.ser_a   = shifting & opd_lsb[0];
    assign bus.ser_b   = shifting & opd_lsb[1];
    assign bus.ser_cin = shifting & ((cnt_reg == '0) ? cin_reg : bus.ser_cout);

    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.out_valid = (state_reg == DONE);
    assign bus.out_sum   = sum_q;
    assign bus.out_cout  = cout_reg;

endmodule

// File: tb/tb_serial_add_seq.sv
// Directed and random checks of serial_add_seq driving a registered-carry adder stage.
module tb_serial_add_seq;

    localparam int W = serial_alu_pkg::DEFAULT_WIDTH;

    logic clk = 1'b0;
    logic rst;
    int   n_tests  = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   last_acc = -1;
    int   txn_id   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    serial_add_seq_if #(.WIDTH(W)) bus ();

    serial_add_seq #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    full_adder_reg adder (
        .clk   (clk),
        .rst_n (!rst),
        .add_1 (bus.ser_a),
        .add_2 (bus.ser_b),
        .c_in  (bus.ser_cin),
        .s     (bus.ser_s),
        .c_out (bus.ser_cout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One transaction, entered during the low clock phase with the block idle.
    task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                           input int stall, input bit hold_valid,
                           input logic [W-1:0] na, input logic [W-1:0] nb, input logic ncin);
        logic [W:0] exp;
        logic       c;
        int         n;
        bit         seen;
        exp = {1'b0, a} + {1'b0, b} + (W+1)'(cin);

        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_cin    = cin;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        #1;
        check("in_ready_before_accept", bus.in_ready, 1);
        if (last_acc >= 0) check("accept_spacing_ge_11", 32'((cyc - last_acc) >= 11), 1);
        last_acc = cyc;

        @(posedge clk);
        @(negedge clk);
        // Operand changes after the accept edge must be ignored.
        bus.in_valid = 1'b0;
        bus.in_a     = W'($urandom);
        bus.in_b     = W'($urandom);
        bus.in_cin   = 1'($urandom);

        c = cin;
        for (int k = 0; k < W; k++) begin
            #1;
            check($sformatf("ser_a_k%0d", k), bus.ser_a, a[k]);
            check($sformatf("ser_b_k%0d", k), bus.ser_b, b[k]);
            check($sformatf("ser_cin_k%0d", k), bus.ser_cin, c);
            check("in_ready_busy", bus.in_ready, 0);
            check("out_valid_busy", bus.out_valid, 0);
            c = (a[k] & b[k]) | (c & (a[k] ^ b[k]));
            @(negedge clk);
        end

        // FLUSH cycle
        #1;
        check("ser_zero_flush", {29'd0, bus.ser_a, bus.ser_b, bus.ser_cin}, 0);
        check("out_valid_flush", bus.out_valid, 0);

        n = W + 1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            n++;
            #1;
            if (bus.out_valid) seen = 1'b1;
        end
        check("latency_to_out_valid", n, W + 2);
        if (!seen) return;

        check("out_sum", bus.out_sum, exp[W-1:0]);
        check("out_cout", bus.out_cout, exp[W]);
        check("ser_zero_done", {29'd0, bus.ser_a, bus.ser_b, bus.ser_cin}, 0);

        if (hold_valid) begin
            bus.in_a     = na;
            bus.in_b     = nb;
            bus.in_cin   = ncin;
            bus.in_valid = 1'b1;
        end

        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            #1;
            check("stall_out_valid", bus.out_valid, 1);
            check("stall_in_ready", bus.in_ready, 0);
            check("stall_out_sum", bus.out_sum, exp[W-1:0]);
            check("stall_out_cout", bus.out_cout, exp[W]);
        end

        bus.out_ready = 1'b1;
        @(negedge clk);
        #1;
        check("in_ready_after_handoff", bus.in_ready, 1);
        check("out_valid_after_handoff", bus.out_valid, 0);
        bus.out_ready = 1'b0;

        $display("[TB] txn %0d: a=0x%02h b=0x%02h cin=%0b stall=%0d -> sum=0x%02h cout=%0b",
                 txn_id, a, b, cin, stall, exp[W-1:0], exp[W]);
        txn_id++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] ca, cb, na, nb;
        logic         cc, nc;
        bit           hv;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_cin    = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state
        #1;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_sum", bus.out_sum, 0);
        check("rst_out_cout", bus.out_cout, 0);
        check("rst_ser", {29'd0, bus.ser_a, bus.ser_b, bus.ser_cin}, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Directed vectors
        run_txn(8'h5A, 8'h3C, 1'b0, 0, 1'b0, 8'h00, 8'h00, 1'b0);
        run_txn(8'hFF, 8'h01, 1'b0, 0, 1'b0, 8'h00, 8'h00, 1'b0);
        run_txn(8'hFF, 8'hFF, 1'b1, 0, 1'b0, 8'h00, 8'h00, 1'b0);

        // Backpressure with the next request already waiting on in_valid
        run_txn(8'h21, 8'h43, 1'b1, 5, 1'b1, 8'h10, 8'h20, 1'b0);
        run_txn(8'h10, 8'h20, 1'b0, 0, 1'b0, 8'h00, 8'h00, 1'b0);

        // Reset during bit cycle k=3
        bus.in_a     = 8'h07;
        bus.in_b     = 8'h00;
        bus.in_cin   = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("pre_reset_partial_sum", bus.out_sum, 8'hE0);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_in_ready", bus.in_ready, 1);
        check("midrst_out_sum", bus.out_sum, 0);
        check("midrst_ser", {29'd0, bus.ser_a, bus.ser_b, bus.ser_cin}, 0);
        @(negedge clk);
        rst = 1'b0;
        last_acc = -1;
        #1;
        run_txn(8'h12, 8'h34, 1'b0, 0, 1'b0, 8'h00, 8'h00, 1'b0);

        // Random back-to-back with stalls and early-held in_valid
        na = W'($urandom);
        nb = W'($urandom);
        nc = 1'($urandom);
        for (int i = 0; i < 100; i++) begin
            ca = na;
            cb = nb;
            cc = nc;
            na = W'($urandom);
            nb = W'($urandom);
            nc = 1'($urandom);
            hv = (i < 99) ? 1'($urandom) : 1'b0;
            run_txn(ca, cb, cc, int'($urandom_range(0, 3)), hv, na, nb, nc);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
